// File: rtl/pi_inv_stream_if.sv
// Lane-serial stream bundle for the inverse-pi block: input lanes in, reordered lanes out.
interface pi_inv_stream_if #(
  parameter int unsigned LANE_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pi_inv_stream.sv
// Streaming inverse of Keccak pi: takes 25 lanes in b-order and returns them in a-order,
// using two ping-pong banks so one state fills while the other drains.
module pi_inv_stream #(
  parameter int unsigned LANE_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pi_inv_stream_if.slave  strm,
  output logic            busy
);
  localparam int unsigned LANES = 25;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LANES - 1);

  logic [LANE_W-1:0] bank_q [2][LANES];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              in_fire;
  logic              out_fire;

  // Output lane k of a state reads input lane src_idx(k): a[x][y] = b[y][(2x+3y) mod 5].
  function automatic logic [CNT_W-1:0] src_idx(input logic [CNT_W-1:0] k);
    case (k)
      5'd0:  src_idx = 5'd0;
      5'd1:  src_idx = 5'd8;
      5'd2:  src_idx = 5'd11;
      5'd3:  src_idx = 5'd19;
      5'd4:  src_idx = 5'd22;
      5'd5:  src_idx = 5'd2;
      5'd6:  src_idx = 5'd5;
      5'd7:  src_idx = 5'd13;
      5'd8:  src_idx = 5'd16;
      5'd9:  src_idx = 5'd24;
      5'd10: src_idx = 5'd4;
      5'd11: src_idx = 5'd7;
      5'd12: src_idx = 5'd10;
      5'd13: src_idx = 5'd18;
      5'd14: src_idx = 5'd21;
      5'd15: src_idx = 5'd1;
      5'd16: src_idx = 5'd9;
      5'd17: src_idx = 5'd12;
      5'd18: src_idx = 5'd15;
      5'd19: src_idx = 5'd23;
      5'd20: src_idx = 5'd3;
      5'd21: src_idx = 5'd6;
      5'd22: src_idx = 5'd14;
      5'd23: src_idx = 5'd17;
      5'd24: src_idx = 5'd20;
      default: src_idx = 5'd0;
    endcase
  endfunction

  assign strm.in_ready  = !full_q[wr_bank_q];
  assign strm.out_valid = full_q[rd_bank_q];
  assign strm.out_data  = bank_q[rd_bank_q][src_idx(rd_cnt_q)];
  assign strm.out_last  = full_q[rd_bank_q] && (rd_cnt_q == LAST_IDX);
  assign busy           = (|full_q) || (wr_cnt_q != '0);

  assign in_fire  = strm.in_valid && !full_q[wr_bank_q];
  assign out_fire = full_q[rd_bank_q] && strm.out_ready;

  // Pointer and full-flag update; flush overrides both handshakes.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    if (flush) begin
      full_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
    end else begin
      if (in_fire) begin
        if (wr_cnt_q == LAST_IDX) begin
          wr_cnt_d          = '0;
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = !wr_bank_q;
        end else begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
      end
      if (out_fire) begin
        if (rd_cnt_q == LAST_IDX) begin
          rd_cnt_d          = '0;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
        end else begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Lane storage is deliberately left out of reset/flush; the full flags gate its visibility.
  always_ff @(posedge clk) begin
    if (!flush && in_fire) begin
      bank_q[wr_bank_q][wr_cnt_q] <= strm.in_data;
    end
  end
endmodule

// File: tb/tb_pi_inv_stream.sv
// Self-checking bench for pi_inv_stream against a lane-queue model of the inverse pi step.
module tb_pi_inv_stream;
  localparam int unsigned LANE_W = 64;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  always #5 clk = ~clk;

  pi_inv_stream_if #(.LANE_W(LANE_W)) bus ();

  pi_inv_stream #(.LANE_W(LANE_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .strm  (bus.slave),
    .busy  (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  bit rt_on = 1'b0;

  logic [LANE_W-1:0] src_q [$];
  logic [LANE_W-1:0] inb [$];
  logic [LANE_W-1:0] exp_q [$];
  logic [LANE_W-1:0] rt_q [$];
  logic [LANE_W-1:0] out_log [$];

  int tp1 [25] = '{0, 8, 11, 19, 22, 2, 5, 13, 16, 24, 4, 7, 10, 18, 21,
                   1, 9, 12, 15, 23, 3, 6, 14, 17, 20};

  task automatic chk(input string tag, input logic [LANE_W-1:0] obs, input logic [LANE_W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model: a completed b-state yields a[x][y] = b[y][(2x+3y) mod 5], emitted with k = 5x+y.
  function automatic void push_state();
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        exp_q.push_back(inb[5*y + (2*x + 3*y) % 5]);
  endfunction

  function automatic logic [LANE_W-1:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  // One clock: drive at negedge, check against the model, then advance the model.
  task automatic cyc(input bit iv, input bit ordy, input bit fl);
    int pend;
    bit ofire, ifire;
    @(negedge clk);
    flush         = fl;
    bus.in_valid  = iv && !fl && (src_q.size() > 0);
    bus.in_data   = (src_q.size() > 0) ? src_q[0] : rnd64();
    bus.out_ready = ordy;
    #1;
    pend = (exp_q.size() + 24) / 25;
    chk("in_ready", LANE_W'(bus.in_ready), LANE_W'(pend < 2));
    chk("out_valid", LANE_W'(bus.out_valid), LANE_W'(pend > 0));
    chk("busy", LANE_W'(busy), LANE_W'((pend > 0) || (inb.size() > 0)));
    if (pend > 0) begin
      chk("out_data", bus.out_data, exp_q[0]);
      chk("out_last", LANE_W'(bus.out_last), LANE_W'(exp_q.size() % 25 == 1));
      if (rt_on && rt_q.size() > 0) chk("roundtrip", bus.out_data, rt_q[0]);
    end else begin
      chk("out_last_idle", LANE_W'(bus.out_last), LANE_W'(0));
    end
    if (fl) begin
      exp_q.delete();
      inb.delete();
      src_q.delete();
    end else begin
      ofire = (pend > 0) && ordy;
      ifire = bus.in_valid && (pend < 2);
      if (ofire) begin
        out_log.push_back(bus.out_data);
        void'(exp_q.pop_front());
        if (rt_on && rt_q.size() > 0) void'(rt_q.pop_front());
      end
      if (ifire) begin
        inb.push_back(src_q.pop_front());
        n_acc++;
        if (inb.size() == 25) begin
          push_state();
          inb.delete();
        end
      end
    end
  endtask

  task automatic run_until_empty(input bit rnd, input int budget);
    int b = budget;
    while ((src_q.size() > 0 || exp_q.size() > 0 || inb.size() > 0) && b > 0) begin
      cyc(rnd ? 1'($urandom_range(0, 1)) : 1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      b--;
    end
    chk("drain_timeout", LANE_W'(src_q.size() + exp_q.size() + inb.size()), LANE_W'(0));
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_log(input string tag, input int base);
    chk({tag, "_count"}, LANE_W'(out_log.size()), LANE_W'(25));
    for (int k = 0; k < 25 && k < out_log.size(); k++)
      chk(tag, out_log[k], LANE_W'(base + tp1[k]));
  endtask

  initial begin
    logic [LANE_W-1:0] a [25];
    logic [LANE_W-1:0] b [25];
    int acc0;
    int bud;

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", LANE_W'(bus.in_ready), LANE_W'(1));
    chk("rst_out_valid", LANE_W'(bus.out_valid), LANE_W'(0));
    chk("rst_out_last", LANE_W'(bus.out_last), LANE_W'(0));
    chk("rst_busy", LANE_W'(busy), LANE_W'(0));
    rst = 1'b0;

    // Single state with lane value = index.
    out_log.delete();
    for (int k = 0; k < 25; k++) src_q.push_back(LANE_W'(k));
    run_until_empty(1'b0, 200);
    check_log("single", 0);

    // Round trip: random a-states through a forward pi, three back-to-back.
    rt_on = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 25; k++) a[k] = rnd64();
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          b[5*y + (2*x + 3*y) % 5] = a[5*x + y];
      for (int k = 0; k < 25; k++) begin
        src_q.push_back(b[k]);
        rt_q.push_back(a[k]);
      end
    end
    acc0 = n_acc;
    repeat (75) cyc(1'b1, 1'b1, 1'b0);
    chk("rt_no_idle", LANE_W'(n_acc - acc0), LANE_W'(75));
    run_until_empty(1'b0, 200);
    chk("rt_all_out", LANE_W'(rt_q.size()), LANE_W'(0));
    rt_on = 1'b0;

    // Output stalled: only two states fit.
    for (int k = 0; k < 75; k++) src_q.push_back(rnd64());
    acc0 = n_acc;
    repeat (60) cyc(1'b1, 1'b0, 1'b0);
    chk("stall_accepted", LANE_W'(n_acc - acc0), LANE_W'(50));
    chk("stall_in_ready", LANE_W'(bus.in_ready), LANE_W'(0));
    run_until_empty(1'b0, 400);

    // Random handshakes over ten states.
    for (int k = 0; k < 250; k++) src_q.push_back(rnd64());
    run_until_empty(1'b1, 4000);

    // Flush after a partial state.
    for (int k = 0; k < 12; k++) src_q.push_back(LANE_W'(500 + k));
    repeat (12) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    out_log.delete();
    for (int k = 0; k < 25; k++) src_q.push_back(LANE_W'(100 + k));
    run_until_empty(1'b0, 200);
    check_log("flush", 100);

    // Asynchronous reset while lane 7 of a state is being drained.
    for (int k = 0; k < 50; k++) src_q.push_back(rnd64());
    bud = 300;
    while (!(exp_q.size() > 0 && exp_q.size() % 25 == 18) && bud > 0) begin
      cyc(1'b1, 1'b1, 1'b0);
      bud--;
    end
    chk("rst_reach_lane7", LANE_W'(exp_q.size() % 25), LANE_W'(18));
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", LANE_W'(bus.out_valid), LANE_W'(0));
    chk("arst_in_ready", LANE_W'(bus.in_ready), LANE_W'(1));
    chk("arst_busy", LANE_W'(busy), LANE_W'(0));
    exp_q.delete();
    inb.delete();
    src_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_log.delete();
    for (int k = 0; k < 25; k++) src_q.push_back(LANE_W'(200 + k));
    run_until_empty(1'b0, 200);
    check_log("after_rst", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
